// File: rtl/bus_bridge_master_pkg.sv
// Shared definitions for the bus bridge master: FSM state encodings,
// UART frame field offsets and timeout counter sizing.
package bus_bridge_master_pkg;

  // Transaction FSM states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_WDATA = 3'd3;
  localparam logic [2:0] ST_RWAIT = 3'd4;
  localparam logic [2:0] ST_UTX   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  // UART serialiser/deserialiser states
  localparam logic [1:0] U_IDLE  = 2'd0;
  localparam logic [1:0] U_START = 2'd1;
  localparam logic [1:0] U_DATA  = 2'd2;
  localparam logic [1:0] U_STOP  = 2'd3;

  // Received frame layout {addr, wdata, mode}
  localparam int MODE_BIT  = 0;
  localparam int WDATA_LSB = 1;

  // Watchdog for REQ and RWAIT
  localparam int                   TMO_WIDTH = 16;
  localparam logic [TMO_WIDTH-1:0] TMO_LIMIT = 16'hFFFF;

  // The address sits directly above the write data and the mode bit.
  function automatic int frame_addr_lsb(input int data_width);
    return data_width + WDATA_LSB;
  endfunction

endpackage

// File: rtl/bus_bridge_master_uart.sv
// 8N1-style UART with independent TX and RX widths. One start bit (0),
// data LSB first, one stop bit (1). rx_ready pulses for one cycle when a
// frame with a valid stop bit has been received.
module bus_bridge_master_uart
  import bus_bridge_master_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int TX_WIDTH     = 8,
  parameter int RX_WIDTH     = 21
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                tx_en,
  input  logic [TX_WIDTH-1:0] tx_data,
  output logic                tx_busy,
  output logic                tx,
  input  logic                rx,
  output logic                rx_ready,
  output logic [RX_WIDTH-1:0] rx_data
);

  localparam int CW    = $clog2(CLKS_PER_BIT + 1);
  localparam int TXB_W = $clog2(TX_WIDTH + 1);
  localparam int RXB_W = $clog2(RX_WIDTH + 1);

  localparam logic [CW-1:0]    CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    CLK_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TXB_W-1:0] TX_LAST  = TXB_W'(TX_WIDTH - 1);
  localparam logic [RXB_W-1:0] RX_LAST  = RXB_W'(RX_WIDTH - 1);

  logic [1:0]          tx_state;
  logic [CW-1:0]       tx_clk;
  logic [TXB_W-1:0]    tx_bit;
  logic [TX_WIDTH-1:0] tx_sh;

  logic [1:0]          rx_state;
  logic [CW-1:0]       rx_clk;
  logic [RXB_W-1:0]    rx_bit;
  logic [RX_WIDTH-1:0] rx_sh;
  logic                rx_meta;
  logic                rx_sync;

  assign tx_busy = (tx_state != U_IDLE);

  // Transmit: start bit, TX_WIDTH data bits LSB first, stop bit
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state <= U_IDLE;
      tx       <= 1'b1;
      tx_clk   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
    end else begin
      case (tx_state)
        U_IDLE: begin
          tx <= 1'b1;
          if (tx_en) begin
            tx_sh    <= tx_data;
            tx       <= 1'b0;
            tx_clk   <= '0;
            tx_state <= U_START;
          end
        end
        U_START: begin
          if (tx_clk == CLK_LAST) begin
            tx_clk   <= '0;
            tx       <= tx_sh[0];
            tx_sh    <= tx_sh >> 1;
            tx_bit   <= '0;
            tx_state <= U_DATA;
          end else begin
            tx_clk <= tx_clk + 1'b1;
          end
        end
        U_DATA: begin
          if (tx_clk == CLK_LAST) begin
            tx_clk <= '0;
            if (tx_bit == TX_LAST) begin
              tx       <= 1'b1;
              tx_state <= U_STOP;
            end else begin
              tx     <= tx_sh[0];
              tx_sh  <= tx_sh >> 1;
              tx_bit <= tx_bit + 1'b1;
            end
          end else begin
            tx_clk <= tx_clk + 1'b1;
          end
        end
        default: begin
          if (tx_clk == CLK_LAST) begin
            tx_clk   <= '0;
            tx_state <= U_IDLE;
          end else begin
            tx_clk <= tx_clk + 1'b1;
          end
        end
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous RX line (idles high)
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Receive: confirm start bit at mid-bit, then sample each bit mid-bit
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_state <= U_IDLE;
      rx_clk   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_ready <= 1'b0;
    end else begin
      rx_ready <= 1'b0;
      case (rx_state)
        U_IDLE: begin
          if (!rx_sync) begin
            rx_clk   <= '0;
            rx_state <= U_START;
          end
        end
        U_START: begin
          if (rx_clk == CLK_HALF) begin
            rx_clk   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? U_IDLE : U_DATA;
          end else begin
            rx_clk <= rx_clk + 1'b1;
          end
        end
        U_DATA: begin
          if (rx_clk == CLK_LAST) begin
            rx_clk <= '0;
            rx_sh  <= {rx_sync, rx_sh[RX_WIDTH-1:1]};
            if (rx_bit == RX_LAST) begin
              rx_state <= U_STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_clk <= rx_clk + 1'b1;
          end
        end
        default: begin
          if (rx_clk == CLK_LAST) begin
            rx_clk   <= '0;
            rx_state <= U_IDLE;
            if (rx_sync) begin
              rx_data  <= rx_sh;
              rx_ready <= 1'b1;
            end
          end else begin
            rx_clk <= rx_clk + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/bus_bridge_master.sv
// Bus bridge master: takes {addr, wdata, mode} frames from UART RX and
// replays them as bit-serial initiator transactions on the local bus.
// Read data is captured serially and returned as one UART TX frame.
// Optional macro BUS_BRIDGE_MASTER_TIMEOUT_EN adds a watchdog on REQ and
// RWAIT (abort the request, or answer a stalled read with all ones).
//
// Handshake: mvalid qualifies mwdata on every cycle it is high, with no
// backpressure once granted; svalid qualifies mrdata and each cycle with
// svalid high delivers exactly one read bit, gaps simply stall capture.
module bus_bridge_master
  import bus_bridge_master_pkg::*;
#(
  parameter int DATA_WIDTH            = 8,
  parameter int ADDR_WIDTH            = 12,
  parameter int UART_CLOCKS_PER_PULSE = 5208
) (
  input  logic clk,
  input  logic rst,
  output logic mbreq,
  input  logic mbgrant,
  output logic mwdata,
  output logic mmode,
  output logic mvalid,
  input  logic mrdata,
  input  logic svalid,
  input  logic sready,
  output logic u_tx,
  input  logic u_rx,
  output logic busy,
  output logic frame_drop
);

  localparam int FRAME_W  = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam int ADDR_LSB = frame_addr_lsb(DATA_WIDTH);
  localparam int MAX_W    = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W    = $clog2(MAX_W + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  mode_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CNT_W-1:0]      bit_cnt;

  logic                  rx_ready;
  logic [FRAME_W-1:0]    rx_frame;
  logic                  tx_busy;
  logic                  tx_en;

  // Outputs decode directly from state so they are clean in reset and DONE
  always_comb begin
    busy   = (state == ST_REQ)   || (state == ST_ADDR) || (state == ST_WDATA) ||
             (state == ST_RWAIT) || (state == ST_UTX);
    mbreq  = busy;
    mmode  = busy && mode_q;
    mvalid = (state == ST_ADDR) || (state == ST_WDATA);
    mwdata = 1'b0;
    if (state == ST_ADDR) begin
      mwdata = addr_q[0];
    end else if (state == ST_WDATA) begin
      mwdata = wdata_q[0];
    end
    tx_en      = (state == ST_UTX) && !tx_busy;
    frame_drop = rx_ready && (state != ST_IDLE);
  end

`ifdef BUS_BRIDGE_MASTER_TIMEOUT_EN
  logic [TMO_WIDTH-1:0] tmo_cnt;
  logic                 tmo_hit;
  logic                 tmo_run;

  assign tmo_hit = (tmo_cnt == TMO_LIMIT);
  assign tmo_run = ((state == ST_REQ) && !(mbgrant && sready)) ||
                   ((state == ST_RWAIT) && mbgrant && !svalid);

  // Watchdog counts idle waiting cycles, cleared by progress or state change
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (tmo_run && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`endif

  // Transaction FSM with address/write shifters and read capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mode_q  <= 1'b0;
      rdata_q <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_ready) begin
            addr_q  <= rx_frame[ADDR_LSB +: ADDR_WIDTH];
            wdata_q <= rx_frame[WDATA_LSB +: DATA_WIDTH];
            mode_q  <= rx_frame[MODE_BIT];
            rdata_q <= '0;
            bit_cnt <= '0;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mbgrant && sready) begin
            bit_cnt <= '0;
            state   <= ST_ADDR;
          end
`ifdef BUS_BRIDGE_MASTER_TIMEOUT_EN
          else if (tmo_hit) begin
            state <= ST_DONE;
          end
`endif
        end
        ST_ADDR: begin
          if (!mbgrant) begin
            state <= ST_DONE;
          end else begin
            addr_q <= addr_q >> 1;
            if (bit_cnt == ADDR_LAST) begin
              bit_cnt <= '0;
              state   <= mode_q ? ST_WDATA : ST_RWAIT;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_WDATA: begin
          if (!mbgrant) begin
            state <= ST_DONE;
          end else begin
            wdata_q <= wdata_q >> 1;
            if (bit_cnt == DATA_LAST) begin
              state <= ST_DONE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_RWAIT: begin
          if (!mbgrant) begin
            state <= ST_DONE;
          end else if (svalid) begin
            rdata_q <= {mrdata, rdata_q[DATA_WIDTH-1:1]};
            if (bit_cnt == DATA_LAST) begin
              state <= ST_UTX;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
`ifdef BUS_BRIDGE_MASTER_TIMEOUT_EN
          else if (tmo_hit) begin
            rdata_q <= '1;
            state   <= ST_UTX;
          end
`endif
        end
        ST_UTX: begin
          if (!tx_busy) begin
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  bus_bridge_master_uart #(
    .CLKS_PER_BIT (UART_CLOCKS_PER_PULSE),
    .TX_WIDTH     (DATA_WIDTH),
    .RX_WIDTH     (FRAME_W)
  ) u_uart (
    .clk      (clk),
    .rstn     (~rst),
    .tx_en    (tx_en),
    .tx_data  (rdata_q),
    .tx_busy  (tx_busy),
    .tx       (u_tx),
    .rx       (u_rx),
    .rx_ready (rx_ready),
    .rx_data  (rx_frame)
  );

endmodule

// File: tb/tb_bus_bridge_master.sv
// Testbench for bus_bridge_master: drives UART frames, plays the arbiter and
// slave, decodes returned UART frames and checks bus traces against a
// frame-level model of the expected serial stream.
module tb_bus_bridge_master;

  localparam int DW  = 8;
  localparam int AW  = 12;
  localparam int CPB = 4;
  localparam int FW  = AW + DW + 1;

  logic clk, rst;
  logic mbreq, mbgrant, mwdata, mmode, mvalid, mrdata, svalid, sready;
  logic u_tx, u_rx, busy, frame_drop;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];

  typedef struct packed {
    logic busy;
    logic mbreq;
    logic mvalid;
    logic mwdata;
    logic mmode;
    logic frame_drop;
    logic u_tx;
  } smp_t;

  smp_t trace[$];
  bit   rec_en = 1'b0;

  bus_bridge_master #(
    .DATA_WIDTH            (DW),
    .ADDR_WIDTH            (AW),
    .UART_CLOCKS_PER_PULSE (CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mbreq      (mbreq),
    .mbgrant    (mbgrant),
    .mwdata     (mwdata),
    .mmode      (mmode),
    .mvalid     (mvalid),
    .mrdata     (mrdata),
    .svalid     (svalid),
    .sready     (sready),
    .u_tx       (u_tx),
    .u_rx       (u_rx),
    .busy       (busy),
    .frame_drop (frame_drop)
  );

  // Clock and safety watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Bus trace recorder
  always @(negedge clk) begin
    if (rec_en) trace.push_back('{busy, mbreq, mvalid, mwdata, mmode, frame_drop, u_tx});
  end

  // UART decoder for read responses coming back on u_tx
  initial begin
    logic [DW-1:0] b;
    b = '0;
    forever begin
      @(negedge clk);
      if (!rst && u_tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = u_tx;
        end
        repeat (CPB) @(negedge clk);
        got_q.push_back(b);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk_frame(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                             input logic m);
    return {a, d, m};
  endfunction

  // Drive one UART frame: start, data LSB first, stop
  task automatic uart_send(input logic [FW-1:0] f);
    u_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < FW; i++) begin
      u_rx = f[i];
      tick(CPB);
    end
    u_rx = 1'b1;
    tick(CPB);
  endtask

  function automatic logic sig(input int which);
    return (which == 0) ? busy : mvalid;
  endfunction

  // Bounded wait for busy (0) or mvalid (1) to reach lvl
  task automatic wait_for(input string tag, input int which, input logic lvl, input int budget);
    int n;
    n = 0;
    while (sig(which) !== lvl && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, " reached"}, 32'(sig(which) === lvl), 32'd1);
  endtask

  // Slave returns d LSB first with random svalid gaps
  task automatic slave_send(input logic [DW-1:0] d, input int max_gap);
    for (int i = 0; i < DW; i++) begin
      svalid = 1'b0;
      tick($urandom_range(max_gap, 0));
      svalid = 1'b1;
      mrdata = d[i];
      tick(1);
    end
    svalid = 1'b0;
    mrdata = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input int budget);
    int n;
    n = 0;
    while (got_q.size() == 0 && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, " arrived"}, got_q.size(), 32'd1);
    if (got_q.size() > 0 && exp_q.size() > 0) check({tag, " data"}, got_q.pop_front(), exp_q.pop_front());
  endtask

  // Compare a recorded trace with the stream the frame should produce
  task automatic analyze(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit wr, input bit chk_lat, input int exp_drop);
    int fv, lv, nv, fb, nb, bad_mode, bad_req, ntx, ndrop;
    logic [31:0] ser, exp_ser;
    fv = -1; lv = -1; nv = 0; fb = -1; nb = 0;
    bad_mode = 0; bad_req = 0; ntx = 0; ndrop = 0; ser = '0;
    foreach (trace[i]) begin
      if (trace[i].busy) begin
        nb++;
        if (fb < 0) fb = i;
      end
      if (trace[i].mvalid) begin
        if (fv < 0) fv = i;
        lv = i;
        ser = ser | (32'(trace[i].mwdata) << nv);
        nv++;
      end
      if (trace[i].mbreq && trace[i].mmode !== wr) bad_mode++;
      if (trace[i].mbreq !== trace[i].busy) bad_req++;
      if (trace[i].u_tx !== 1'b1) ntx++;
      if (trace[i].frame_drop) ndrop++;
    end
    exp_ser = wr ? 32'(d) * 32'd4096 + 32'(a) : 32'(a);
    check({tag, " bit count"}, nv, wr ? AW + DW : AW);
    check({tag, " contiguous"}, lv - fv + 1, wr ? AW + DW : AW);
    check({tag, " serial"}, ser, exp_ser);
    check({tag, " mmode"}, bad_mode, 0);
    check({tag, " mbreq"}, bad_req, 0);
    check({tag, " drops"}, ndrop, exp_drop);
    if (wr) check({tag, " u_tx idle"}, ntx, 0);
    if (chk_lat) check({tag, " latency"}, fv - fb, 1);
    if (chk_lat && wr) check({tag, " busy len"}, nb, AW + DW + 1);
  endtask

  task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit chk_lat);
    trace.delete();
    rec_en = 1'b1;
    uart_send(mk_frame(a, d, 1'b1));
    wait_for({tag, " busy rise"}, 0, 1'b1, 50);
    wait_for({tag, " busy fall"}, 0, 1'b0, 200);
    tick(2);
    rec_en = 1'b0;
    analyze(tag, a, d, 1'b1, chk_lat, 0);
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back(d);
    trace.delete();
    rec_en = 1'b1;
    uart_send(mk_frame(a, 8'h00, 1'b0));
    wait_for({tag, " addr start"}, 1, 1'b1, 50);
    wait_for({tag, " addr end"}, 1, 1'b0, 50);
    slave_send(d, 3);
    wait_for({tag, " busy fall"}, 0, 1'b0, 50);
    wait_resp(tag, 200);
    rec_en = 1'b0;
    analyze(tag, a, d, 1'b0, 1'b1, 0);
  endtask

  initial begin
    int viol;
    rst = 1'b1; mbgrant = 1'b1; sready = 1'b1;
    svalid = 1'b0; mrdata = 1'b0; u_rx = 1'b1;
    tick(3);
    check("reset outputs", {busy, mbreq, mvalid, mwdata, mmode, frame_drop}, 0);
    check("reset u_tx", u_tx, 1);
    rst = 1'b0;
    tick(2);
    check("idle outputs", {busy, mbreq, mvalid, mwdata, mmode, frame_drop}, 0);

    // Directed write and read
    do_write("wr 5A3/C7", 12'h5A3, 8'hC7, 1'b1);
    do_read("rd 010/3C", 12'h010, 8'h3C);

    // Grant held off for 50 cycles
    mbgrant = 1'b0;
    trace.delete();
    rec_en = 1'b1;
    uart_send(mk_frame(12'h2B4, 8'h91, 1'b1));
    wait_for("grant busy rise", 0, 1'b1, 50);
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      if (mbreq !== 1'b1 || mvalid !== 1'b0) viol++;
      tick(1);
    end
    check("grant wait hold", viol, 0);
    mbgrant = 1'b1;
    tick(1);
    check("grant addr start", mvalid, 1);
    wait_for("grant busy fall", 0, 1'b0, 100);
    tick(2);
    rec_en = 1'b0;
    analyze("grant wr", 12'h2B4, 8'h91, 1'b1, 1'b0, 0);

    // Second frame during RWAIT is dropped
    exp_q.push_back(8'hA6);
    trace.delete();
    rec_en = 1'b1;
    uart_send(mk_frame(12'h7E1, 8'h00, 1'b0));
    wait_for("ovl addr start", 1, 1'b1, 50);
    wait_for("ovl addr end", 1, 1'b0, 50);
    fork
      uart_send(mk_frame(12'h333, 8'h55, 1'b1));
      begin
        tick(110);
        slave_send(8'hA6, 2);
      end
    join
    wait_for("ovl busy fall", 0, 1'b0, 50);
    wait_resp("ovl", 200);
    tick(60);
    rec_en = 1'b0;
    analyze("ovl rd", 12'h7E1, 8'hA6, 1'b0, 1'b1, 1);
    check("ovl extra resp", got_q.size(), 0);

    // Grant lost during ADDR aborts without a response
    uart_send(mk_frame(12'h444, 8'h00, 1'b0));
    wait_for("gl addr start", 1, 1'b1, 50);
    tick(3);
    mbgrant = 1'b0;
    tick(1);
    check("gl abort", {busy, mbreq, mvalid}, 0);
    mbgrant = 1'b1;
    tick(100);
    check("gl no resp", got_q.size(), 0);
    check("gl idle", busy, 0);

    // Reset pulse during WDATA
    uart_send(mk_frame(12'hABC, 8'h5E, 1'b1));
    wait_for("rst addr start", 1, 1'b1, 50);
    tick(14);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst outputs", {busy, mbreq, mvalid, mwdata, mmode, frame_drop}, 0);
    check("rst u_tx", u_tx, 1);
    tick(30);
    check("rst no resume", busy, 0);
    do_write("post-rst wr", 12'h0F3, 8'h2D, 1'b1);

    // Randomised transactions
    for (int i = 0; i < 3; i++) begin
      do_write("rand wr", 12'($urandom_range(4095, 0)), 8'($urandom_range(255, 0)), 1'b1);
      do_read("rand rd", 12'($urandom_range(4095, 0)), 8'($urandom_range(255, 0)));
    end
    check("no stray resp", got_q.size(), 0);

`ifdef BUS_BRIDGE_MASTER_TIMEOUT_EN
    // Read with no slave response ends in an all-ones reply
    exp_q.push_back(8'hFF);
    uart_send(mk_frame(12'h123, 8'h00, 1'b0));
    wait_resp("timeout rd", 70000);
    check("timeout idle", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
